// File: rtl/fpu_wb_tracker.sv
// Issue/writeback tracker for a fixed-latency, non-stallable FP unit.
// Holds the register busy scoreboard and a credit-limited writeback FIFO.
module fpu_wb_tracker #(
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int NREG  = 32,
  parameter int RW    = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [RW-1:0]   issue_rd,
  input  logic [RW-1:0]   issue_rs1,
  input  logic [RW-1:0]   issue_rs2,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  output logic [31:0]     fu_x1,
  output logic [31:0]     fu_x2,
  input  logic [31:0]     fu_y,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RW-1:0]   wb_rd,
  output logic [31:0]     wb_data,
  output logic [NREG-1:0] busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   occ_nxt;
  logic [PW-1:0]   head;
  logic [PW-1:0]   head_nxt;
  logic [PW-1:0]   tail;
  logic [RW-1:0]   fifo_rd   [DEPTH];
  logic [31:0]     fifo_data [DEPTH];
  logic [LAT-1:0]  dl_v;
  logic [RW-1:0]   dl_rd     [LAT];
  logic            hazard;
  logic            accept;
  logic            pop;
  logic            push;
  logic [NREG-1:0] busy_set;
  logic [NREG-1:0] busy_clr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fu_x1 = rs1_data;
  assign fu_x2 = rs2_data;

  // cnt covers in-flight plus queued ops, so a full count means every
  // future capture already has a FIFO slot reserved.
  assign hazard      = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd];
  assign issue_ready = !rstn && !hazard && (cnt < CW'(DEPTH));
  assign accept      = issue_valid & issue_ready;
  assign pop         = wb_valid & wb_ready;
  assign push        = dl_v[LAT-1];

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (accept) busy_set = NREG'(1) << issue_rd;
    if (pop)    busy_clr = NREG'(1) << wb_rd;
    head_nxt = pop ? ptr_inc(head) : head;
    occ_nxt  = occ + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      busy     <= '0;
      dl_v     <= '0;
      cnt      <= '0;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      busy    <= (busy & ~busy_clr) | busy_set;
      dl_v[0] <= accept;
      for (int k = 1; k < LAT; k++) dl_v[k] <= dl_v[k-1];
      cnt      <= cnt + CW'(accept) - CW'(pop);
      occ      <= occ_nxt;
      head     <= head_nxt;
      wb_valid <= (occ_nxt != '0);
      if (push) tail <= ptr_inc(tail);
      // Registered head view: if the FIFO drains to empty this edge, the new
      // head is the entry being captured right now, not a stored slot.
      if (occ_nxt != '0) begin
        if (occ == CW'(pop)) begin
          wb_rd   <= dl_rd[LAT-1];
          wb_data <= fu_y;
        end else begin
          wb_rd   <= fifo_rd[head_nxt];
          wb_data <= fifo_data[head_nxt];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_rd[0] <= issue_rd;
    for (int k = 1; k < LAT; k++) dl_rd[k] <= dl_rd[k-1];
    if (push && !rstn) begin
      fifo_rd[tail]   <= dl_rd[LAT-1];
      fifo_data[tail] <= fu_y;
    end
  end

endmodule

// File: tb/tb_fpu_wb_tracker.sv
// Randomized bench for fpu_wb_tracker against a queue-based reference model.
// The attached unit is modelled as a LAT-deep integer subtract.
module tb_fpu_wb_tracker;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int NREG  = 32;
  localparam int RW    = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  logic [RW-1:0]   issue_rd = '0;
  logic [RW-1:0]   issue_rs1 = '0;
  logic [RW-1:0]   issue_rs2 = '0;
  logic [31:0]     rs1_data = '0;
  logic [31:0]     rs2_data = '0;
  logic [31:0]     fu_x1;
  logic [31:0]     fu_x2;
  logic [31:0]     fu_y;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic [RW-1:0]   wb_rd;
  logic [31:0]     wb_data;
  logic [NREG-1:0] busy;

  fpu_wb_tracker #(.LAT(LAT), .DEPTH(DEPTH), .NREG(NREG), .RW(RW)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fu_x1(fu_x1), .fu_x2(fu_x2), .fu_y(fu_y),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= fu_x1 - fu_x2;
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fu_y = fpipe[LAT-1];

  typedef struct {
    logic [RW-1:0] rd;
    logic [31:0]   data;
    int            due;
  } op_t;

  op_t inflight[$];
  op_t wbq[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  armed = 0;
  bit  zero_chk = 0;
  bit  last_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b = '0;
    foreach (inflight[i]) b[inflight[i].rd] = 1'b1;
    foreach (wbq[i]) b[wbq[i].rd] = 1'b1;
    return b;
  endfunction

  function automatic logic m_ready();
    logic [NREG-1:0] b = m_busy();
    if (rstn) return 1'b0;
    if (b[issue_rs1] || b[issue_rs2] || b[issue_rd]) return 1'b0;
    return (inflight.size() + wbq.size()) < DEPTH;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    logic er, ev, acc, pop;
    @(negedge clk);
    er = m_ready();
    ev = (wbq.size() > 0);
    if (armed) begin
      check("issue_ready", issue_ready, er);
      check("wb_valid", wb_valid, ev);
      check("busy", busy, m_busy());
      check("fu_x1", fu_x1, rs1_data);
      check("fu_x2", fu_x2, rs2_data);
      if (ev) begin
        check("wb_rd", wb_rd, wbq[0].rd);
        check("wb_data", wb_data, wbq[0].data);
      end else if (zero_chk) begin
        check("wb_rd_reset", wb_rd, 0);
        check("wb_data_reset", wb_data, 0);
      end
    end
    acc = issue_valid & er;
    pop = ev & wb_ready;
    @(posedge clk);
    last_acc = 0;
    if (rstn) begin
      inflight.delete();
      wbq.delete();
      armed = 1;
      zero_chk = 1;
    end else begin
      if (pop) void'(wbq.pop_front());
      if (acc) begin
        inflight.push_back('{issue_rd, rs1_data - rs2_data, cyc + LAT + 1});
        last_acc = 1;
      end
      while (inflight.size() > 0 && inflight[0].due == cyc + 1) begin
        wbq.push_back(inflight.pop_front());
        zero_chk = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic offer(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, output int waits);
    issue_valid = 1'b1;
    issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    rs1_data = d1; rs2_data = d2;
    waits = 0;
    last_acc = 0;
    while (!last_acc && waits < 64) begin
      tick();
      waits++;
    end
    check("offer_accepted", last_acc, 1);
    issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    rstn = 1'b1;
    idle(3);
    rstn = 1'b0;
    wb_ready = 1'b1;
    idle(2);

    // single op: latency and result
    offer(5'd3, 5'd0, 5'd0, 32'h3F80_0000, 32'h3F00_0000, w);
    check("single_busy", busy[3], 1);
    n = 0;
    while (!wb_valid && n < 20) begin tick(); n++; end
    check("single_latency", n, LAT);
    check("single_rd", wb_rd, 3);
    check("single_data", wb_data, 32'h0080_0000);
    idle(2);
    check("single_busy_clear", busy[3], 0);

    // back-to-back independent ops
    for (int i = 1; i <= 4; i++) begin
      offer(RW'(i), RW'(16 + i), RW'(20 + i), $urandom, $urandom, w);
      check("b2b_nostall", w, 1);
    end
    idle(LAT + 6);

    // RAW stall
    offer(5'd5, 5'd0, 5'd0, 32'd100, 32'd1, w);
    offer(5'd6, 5'd5, 5'd0, 32'd7, 32'd2, w);
    check("raw_waits", w, LAT + 2);
    idle(LAT + 4);

    // backpressure fills credits
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(RW'(8 + i), 5'd0, 5'd0, $urandom, $urandom, w);
    issue_valid = 1'b1; issue_rd = 5'd12; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    for (int i = 0; i < LAT + 3; i++) tick();
    check("bp_full_stall", issue_ready, 0);
    wb_ready = 1'b1;
    offer(5'd12, 5'd0, 5'd0, $urandom, $urandom, w);
    offer(5'd13, 5'd0, 5'd0, $urandom, $urandom, w);
    idle(LAT + 8);

    // reset with two ops in the delay line and one queued
    wb_ready = 1'b0;
    offer(5'd1, 5'd0, 5'd0, $urandom, $urandom, w);
    offer(5'd2, 5'd0, 5'd0, $urandom, $urandom, w);
    idle(1);
    offer(5'd3, 5'd0, 5'd0, $urandom, $urandom, w);
    rstn = 1'b1;
    idle(1);
    rstn = 1'b0;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    wb_ready = 1'b1;
    idle(LAT + 6);

    // random traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      int bias;
      bias = ((c / 100) % 2) ? 3 : 1;
      issue_valid = 1'($urandom % 2);
      issue_rd  = RW'($urandom % 8);
      issue_rs1 = RW'($urandom % 8);
      issue_rs2 = RW'($urandom % 8);
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      wb_ready  = (($urandom % 4) < bias);
      rstn      = (($urandom % 300) == 0);
      tick();
    end
    rstn = 1'b0;
    wb_ready = 1'b1;
    idle(LAT + 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
